// File: rtl/bpu_update_unit_if.sv
// rtl/bpu_update_unit_if.sv - resolve, training and redirect signal bundle for bpu_update_unit
interface bpu_update_unit_if;
   logic        resolve_valid;
   logic        resolve_ready;
   logic [31:0] resolve_pc;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        resolve_pred_valid;
   logic        resolve_pred_taken;

   logic        update_ready;
   logic        update_valid;
   logic [31:0] update_addr;
   logic        update_taken;

   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport slave (
      input  resolve_valid,
      output resolve_ready,
      input  resolve_pc,
      input  resolve_taken,
      input  resolve_target,
      input  resolve_pred_valid,
      input  resolve_pred_taken,
      input  update_ready,
      output update_valid,
      output update_addr,
      output update_taken,
      output redirect_valid,
      output redirect_pc
   );

   modport master (
      output resolve_valid,
      input  resolve_ready,
      output resolve_pc,
      output resolve_taken,
      output resolve_target,
      output resolve_pred_valid,
      output resolve_pred_taken,
      output update_ready,
      input  update_valid,
      input  update_addr,
      input  update_taken,
      input  redirect_valid,
      input  redirect_pc
   );
endinterface

// File: rtl/bpu_update_unit.sv
// rtl/bpu_update_unit.sv - branch resolve queue feeding predictor training plus mispredict redirect
// Optional statistics counters enabled by defining BPU_UPDATE_STATS_EN.
module bpu_update_unit #(
   parameter int QUEUE_LOG2  = 2,
   parameter int INSTR_BYTES = 4
) (
   input  logic               clk,
   input  logic               rst,
   bpu_update_unit_if.slave   bus
`ifdef BPU_UPDATE_STATS_EN
   ,
   output logic [31:0]        stat_branches,
   output logic [31:0]        stat_mispredicts
`endif
);

   localparam int DEPTH = 1 << QUEUE_LOG2;
   localparam logic [QUEUE_LOG2:0] PTR_ONE = {{QUEUE_LOG2{1'b0}}, 1'b1};
   localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

   logic [QUEUE_LOG2:0]   wr_ptr;
   logic [QUEUE_LOG2:0]   rd_ptr;
   logic [31:0]           mem_pc    [DEPTH];
   logic                  mem_taken [DEPTH];

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  eff_pred;
   logic                  mispredict;
   logic [31:0]           fix_pc;
   logic                  redirect_valid_q;
   logic [31:0]           redirect_pc_q;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[QUEUE_LOG2] != rd_ptr[QUEUE_LOG2]) &&
                  (wr_ptr[QUEUE_LOG2-1:0] == rd_ptr[QUEUE_LOG2-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign push = bus.resolve_valid && !full;
   assign pop  = !empty && bus.update_ready;

   assign eff_pred   = bus.resolve_pred_valid && bus.resolve_pred_taken;
   assign mispredict = push && (bus.resolve_taken != eff_pred);
   assign fix_pc     = bus.resolve_taken ? bus.resolve_target : (bus.resolve_pc + PC_STEP);

   assign bus.resolve_ready  = !full;
   assign bus.update_valid   = !empty;
   assign bus.update_addr    = mem_pc[rd_ptr[QUEUE_LOG2-1:0]];
   assign bus.update_taken   = mem_taken[rd_ptr[QUEUE_LOG2-1:0]];
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is left unreset; it is only ever read through a non-empty head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr[QUEUE_LOG2-1:0]]    <= bus.resolve_pc;
         mem_taken[wr_ptr[QUEUE_LOG2-1:0]] <= bus.resolve_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= mispredict;
         if (mispredict) begin
            redirect_pc_q <= fix_pc;
         end
      end
   end

`ifdef BPU_UPDATE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (push) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (mispredict) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bpu_update_unit.sv
// tb/tb_bpu_update_unit.sv - self-checking bench for bpu_update_unit against a queue-based model
module tb_bpu_update_unit;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   bpu_update_unit_if bus();

`ifdef BPU_UPDATE_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   bpu_update_unit #(.QUEUE_LOG2(2), .INSTR_BYTES(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
`ifdef BPU_UPDATE_STATS_EN
      ,
      .stat_branches(stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
   } ent_t;

   ent_t        q[$];
   logic        m_rv;
   logic [31:0] m_rpc;
   logic [31:0] m_br;
   logic [31:0] m_mp;

   task automatic model_reset();
      q.delete();
      m_rv  = 1'b0;
      m_rpc = 32'd0;
      m_br  = 32'd0;
      m_mp  = 32'd0;
   endtask

   task automatic model_step();
      bit acc, pop, eff, mis;
      acc = bus.resolve_valid && (q.size() < DEPTH);
      pop = bus.update_ready && (q.size() != 0);
      eff = bus.resolve_pred_valid ? bus.resolve_pred_taken : 1'b0;
      mis = acc && (bus.resolve_taken != eff);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({bus.resolve_pc, bus.resolve_taken});
      m_rv = mis;
      if (mis) m_rpc = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
      if (acc) m_br = m_br + 32'd1;
      if (mis) m_mp = m_mp + 32'd1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.resolve_valid      = 1'b0;
      bus.resolve_pc         = 32'd0;
      bus.resolve_taken      = 1'b0;
      bus.resolve_target     = 32'd0;
      bus.resolve_pred_valid = 1'b0;
      bus.resolve_pred_taken = 1'b0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic pv, input logic pt);
      bus.resolve_valid      = 1'b1;
      bus.resolve_pc         = pc;
      bus.resolve_taken      = tk;
      bus.resolve_target     = tgt;
      bus.resolve_pred_valid = pv;
      bus.resolve_pred_taken = pt;
   endtask

   task automatic do_reset();
      set_idle();
      bus.update_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.resolve_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b want 1", bus.resolve_ready);
      end
      checks++;
      if (bus.update_valid !== 1'b0) begin
         errors++; $display("FAIL reset_update_valid got %b want 0", bus.update_valid);
      end
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         errors++; $display("FAIL reset_redirect_valid got %b want 0", bus.redirect_valid);
      end
      checks++;
      if (bus.redirect_pc !== 32'd0) begin
         errors++; $display("FAIL reset_redirect_pc got %h want 0", bus.redirect_pc);
      end
   endtask

   task automatic test_single_accept();
      do_reset();
      drive(32'h100, 1'b1, 32'h40, 1'b1, 1'b1);
      #1;
      checks++;
      if (bus.update_valid !== 1'b0) begin
         errors++; $display("FAIL no_bypass got %b want 0", bus.update_valid);
      end
      tick();
      set_idle();
      checks++;
      if (bus.update_valid !== 1'b1 || bus.update_addr !== 32'h100 || bus.update_taken !== 1'b1) begin
         errors++;
         $display("FAIL single_update got v=%b a=%h t=%b want v=1 a=00000100 t=1",
                  bus.update_valid, bus.update_addr, bus.update_taken);
      end
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         errors++; $display("FAIL single_no_redirect got %b want 0", bus.redirect_valid);
      end
      tick();
      checks++;
      if (bus.update_valid !== 1'b0) begin
         errors++; $display("FAIL single_popped got %b want 0", bus.update_valid);
      end
   endtask

   task automatic test_mispredict_not_taken();
      do_reset();
      drive(32'h200, 1'b0, 32'h999, 1'b1, 1'b1);
      tick();
      set_idle();
      checks++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h204) begin
         errors++;
         $display("FAIL mispred_nt got v=%b pc=%h want v=1 pc=00000204", bus.redirect_valid, bus.redirect_pc);
      end
      tick();
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         errors++; $display("FAIL mispred_nt_pulse got %b want 0", bus.redirect_valid);
      end
   endtask

   task automatic test_fallback();
      do_reset();
      bus.update_ready = 1'b0;
      drive(32'h300, 1'b1, 32'h80, 1'b0, 1'b1);
      tick();
      set_idle();
      checks++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin
         errors++;
         $display("FAIL fallback_redirect got v=%b pc=%h want v=1 pc=00000080", bus.redirect_valid, bus.redirect_pc);
      end
      checks++;
      if (bus.update_valid !== 1'b1 || bus.update_addr !== 32'h300 || bus.update_taken !== 1'b1) begin
         errors++;
         $display("FAIL fallback_entry got v=%b a=%h t=%b want v=1 a=00000300 t=1",
                  bus.update_valid, bus.update_addr, bus.update_taken);
      end
      bus.update_ready = 1'b1;
      tick();
   endtask

   task automatic test_full();
      logic [31:0] pcs [4];
      do_reset();
      bus.update_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pcs[i] = 32'h1000 + 32'(i * 16);
         drive(pcs[i], 1'b0, 32'h0, 1'b0, 1'b0);
         tick();
      end
      checks++;
      if (bus.resolve_ready !== 1'b0) begin
         errors++; $display("FAIL full_ready got %b want 0", bus.resolve_ready);
      end
      drive(32'hDEAD0000, 1'b1, 32'h5000, 1'b0, 1'b0);
      tick();
      set_idle();
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         errors++; $display("FAIL full_reject_redirect got %b want 0", bus.redirect_valid);
      end
      bus.update_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.update_valid !== 1'b1 || bus.update_addr !== pcs[i]) begin
            errors++;
            $display("FAIL full_drain%0d got v=%b a=%h want v=1 a=%h", i, bus.update_valid, bus.update_addr, pcs[i]);
         end
         tick();
         if (i == 0) begin
            checks++;
            if (bus.resolve_ready !== 1'b1) begin
               errors++; $display("FAIL full_ready_reassert got %b want 1", bus.resolve_ready);
            end
         end
      end
      checks++;
      if (bus.update_valid !== 1'b0) begin
         errors++; $display("FAIL full_empty got %b want 0", bus.update_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.update_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h2000 + 32'(i * 4), 1'b1, 32'h0, 1'b1, 1'b1);
         tick();
      end
      set_idle();
      rst = 1'b1;
      #2;
      model_reset();
      checks++;
      if (bus.update_valid !== 1'b0 || bus.resolve_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_async got v=%b r=%b want v=0 r=1", bus.update_valid, bus.resolve_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.update_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (bus.update_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_stale%0d got %b want 0", i, bus.update_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(32'h400, 1'b1, 32'h1000, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1000) begin
         errors++;
         $display("FAIL b2b_first got v=%b pc=%h want v=1 pc=00001000", bus.redirect_valid, bus.redirect_pc);
      end
      drive(32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      set_idle();
      checks++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0) begin
         errors++;
         $display("FAIL b2b_second_wrap got v=%b pc=%h want v=1 pc=00000000", bus.redirect_valid, bus.redirect_pc);
      end
      tick();
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end got %b want 0", bus.redirect_valid);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         bus.resolve_valid      = ($urandom_range(0, 3) != 0);
         bus.resolve_pc         = {$urandom_range(0, 32'hFFFF), 2'b00} << 2;
         bus.resolve_taken      = 1'($urandom);
         bus.resolve_target     = $urandom;
         bus.resolve_pred_valid = 1'($urandom);
         bus.resolve_pred_taken = 1'($urandom);
         bus.update_ready       = ($urandom_range(0, 2) == 0);
         tick();
         checks++;
         if (bus.resolve_ready !== (q.size() < DEPTH)) begin
            errors++; $display("FAIL rand_ready n=%0d got %b want %b", n, bus.resolve_ready, q.size() < DEPTH);
         end
         checks++;
         if (bus.update_valid !== (q.size() != 0)) begin
            errors++; $display("FAIL rand_uvalid n=%0d got %b want %b", n, bus.update_valid, q.size() != 0);
         end
         if (q.size() != 0) begin
            checks++;
            if (bus.update_addr !== q[0].pc || bus.update_taken !== q[0].taken) begin
               errors++;
               $display("FAIL rand_head n=%0d got a=%h t=%b want a=%h t=%b",
                        n, bus.update_addr, bus.update_taken, q[0].pc, q[0].taken);
            end
         end
         checks++;
         if (bus.redirect_valid !== m_rv || bus.redirect_pc !== m_rpc) begin
            errors++;
            $display("FAIL rand_redirect n=%0d got v=%b pc=%h want v=%b pc=%h",
                     n, bus.redirect_valid, bus.redirect_pc, m_rv, m_rpc);
         end
      end
      set_idle();
      bus.update_ready = 1'b1;
   endtask

`ifdef BPU_UPDATE_STATS_EN
   task automatic test_stats();
      do_reset();
      checks++;
      if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
         errors++; $display("FAIL stats_reset got b=%0d m=%0d want 0 0", stat_branches, stat_mispredicts);
      end
      drive(32'h10, 1'b1, 32'h0, 1'b1, 1'b1); tick();
      drive(32'h14, 1'b0, 32'h0, 1'b1, 1'b1); tick();
      drive(32'h18, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      drive(32'h1C, 1'b1, 32'h8, 1'b0, 1'b0); tick();
      drive(32'h20, 1'b0, 32'h0, 1'b1, 1'b0); tick();
      set_idle();
      tick();
      checks++;
      if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
         errors++; $display("FAIL stats_count got b=%0d m=%0d want 5 2", stat_branches, stat_mispredicts);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.update_ready = 1'b1;
      set_idle();
      model_reset();
      test_reset();
      test_single_accept();
      test_mispredict_not_taken();
      test_fallback();
      test_full();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef BPU_UPDATE_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bpu_update_unit.md
BPU_UPDATE_UNIT -- requirements
Module: bpu_update_unit

Interface
REQ-001 Parameter: QUEUE_LOG2, default 2, update-queue depth is 2**QUEUE_LOG2 entries.
REQ-002 Parameter: INSTR_BYTES, default 4, fall-through PC increment.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 resolve_valid  input  1  execute stage presents a resolved conditional branch.
REQ-006 resolve_ready  output  1  unit can accept a resolved branch this cycle.
REQ-007 resolve_pc  input  32  branch instruction address.
REQ-008 resolve_taken  input  1  actual branch outcome.
REQ-009 resolve_target  input  32  taken-path target address.
REQ-010 resolve_pred_valid  input  1  fetch had a valid predictor entry for this branch.
REQ-011 resolve_pred_taken  input  1  direction used by fetch; ignored when resolve_pred_valid=0.
REQ-012 update_ready  input  1  predictor training port can absorb an update this cycle.
REQ-013 update_valid  output  1  training write to predictor.
REQ-014 update_addr  output  32  branch address for training write.
REQ-015 update_taken  output  1  outcome for training write.
REQ-016 redirect_valid  output  1  one-cycle pulse: fetch shall restart at redirect_pc.
REQ-017 redirect_pc  output  32  corrected fetch address.

Function
REQ-018 Accept = resolve_valid && resolve_ready; resolve_ready = !full, independent of same-cycle pop.
REQ-019 Accepted {pc, taken} written to FIFO tail; head visible on update_* no earlier than next cycle (no bypass).
REQ-020 update_valid = !empty; update_addr/update_taken = head entry; pop when update_valid && update_ready.
REQ-021 update_valid held with stable addr/taken until popped.
REQ-022 Simultaneous push and pop when full is impossible (ready low); push and pop in same cycle otherwise keeps count unchanged.
REQ-023 Read/write pointers QUEUE_LOG2+1 bits; wrap modulo depth; full when MSBs differ and low bits equal; empty when equal.
REQ-024 Effective prediction = resolve_pred_valid ? resolve_pred_taken : 0 (not-taken fallback).
REQ-025 Mispredict on accept when resolve_taken != effective prediction.
REQ-026 On mispredict at cycle N: redirect_valid=1 in cycle N+1 only; redirect_pc = resolve_taken ? resolve_target : resolve_pc + INSTR_BYTES (32-bit wrap).
REQ-027 redirect_valid=0 after any non-mispredicting or non-accepted cycle; back-to-back mispredicts give back-to-back pulses.
REQ-028 Branch not accepted (resolve_ready=0) produces neither queue entry nor redirect.

Reset
REQ-029 rst asserted: pointers cleared (empty), update_valid=0, redirect_valid=0, redirect_pc=0, resolve_ready=1 after reset.
REQ-030 rst mid-operation discards all queued entries; no update issued for them.
REQ-031 FIFO storage array not reset; contents unobservable while empty.

Configuration
REQ-032 Macro BPU_UPDATE_STATS_EN defined: outputs stat_branches[31:0] and stat_mispredicts[31:0] exist, increment by 1 per accepted branch / per mispredict, wrap at 2**32, reset to 0.
REQ-033 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-034 Reset, single accept pc=0x100 taken=1 pred_valid=1 pred_taken=1, update_ready=1 -> update_valid next cycle addr=0x100 taken=1, no redirect.
REQ-035 Accept pc=0x200 taken=0 pred_valid=1 pred_taken=1 -> redirect_valid pulse next cycle, redirect_pc=0x204.
REQ-036 Accept pc=0x300 taken=1 target=0x80 pred_valid=0 -> redirect_pc=0x80 one cycle later; queue entry taken=1.
REQ-037 update_ready=0, push 4 branches (QUEUE_LOG2=2) -> resolve_ready=0 after 4th; raise update_ready -> 4 updates in order, one per cycle, ready reasserts after first pop.
REQ-038 Queue 3 entries, assert rst for one cycle -> update_valid=0 immediately, no stale updates afterward.
REQ-039 With BPU_UPDATE_STATS_EN: 5 branches, 2 mispredicts -> stat_branches=5, stat_mispredicts=2.
